// File: rtl/timestamp_record_fifo.sv
// Tags PPS timestamp records with a sequence number and gap flag, buffers them in a
// small first-word-fall-through FIFO, and tracks records lost to overflow.
module timestamp_record_fifo #(
    parameter int UTC_SECONDS_WIDTH       = 6,
    parameter int COUNT_LAST_SECOND_WIDTH = 26,
    parameter int DRIFT_COUNT_WIDTH       = 13,
    parameter int FIFO_DEPTH              = 8,
    parameter int DROP_COUNT_WIDTH        = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               ts_valid,
    input  logic [UTC_SECONDS_WIDTH-1:0]       ts_utc_seconds,
    input  logic [COUNT_LAST_SECOND_WIDTH-1:0] ts_clk_counter,
    input  logic [DRIFT_COUNT_WIDTH-1:0]       ts_drift,
    output logic [63:0]                        m_tdata,
    output logic                               m_tvalid,
    input  logic                               m_tready,
    output logic [$clog2(FIFO_DEPTH):0]        fifo_level,
    output logic                               overflow,
    output logic [DROP_COUNT_WIDTH-1:0]        drop_count,
    input  logic                               clear_overflow
);

    localparam int PTR_W     = $clog2(FIFO_DEPTH);
    localparam int LVL_W     = PTR_W + 1;
    localparam int PAYLOAD_W = UTC_SECONDS_WIDTH + COUNT_LAST_SECOND_WIDTH + DRIFT_COUNT_WIDTH;
    localparam int PAD_W     = 55 - PAYLOAD_W;

    logic [63:0]                 mem [FIFO_DEPTH];
    logic [PTR_W-1:0]            wr_ptr_reg;
    logic [PTR_W-1:0]            rd_ptr_reg;
    logic [PTR_W-1:0]            rd_ptr_inc;
    logic [LVL_W-1:0]            level_reg;
    logic [63:0]                 tdata_reg;
    logic [7:0]                  seq_reg;
    logic                        gap_pending_reg;
    logic                        overflow_reg;
    logic [DROP_COUNT_WIDTH-1:0] drop_count_reg;

    logic        rd_fire;
    logic        full;
    logic        wr_accept;
    logic        drop;
    logic [63:0] record;

    always_comb begin
        rd_fire    = (level_reg != '0) && m_tready;
        full       = (level_reg == LVL_W'(FIFO_DEPTH));
        wr_accept  = ts_valid && (!full || rd_fire);
        drop       = ts_valid && !wr_accept;
        rd_ptr_inc = rd_ptr_reg + 1'b1;
        record     = {seq_reg, gap_pending_reg, {PAD_W{1'b0}},
                      ts_utc_seconds, ts_clk_counter, ts_drift};
    end

    // Storage array carries no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr_reg] <= record;
        end
    end

    // Head register mirrors mem[rd_ptr]; a write into an empty FIFO bypasses the array.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tdata_reg <= '0;
        end else if (rd_fire) begin
            if (level_reg > LVL_W'(1)) begin
                tdata_reg <= mem[rd_ptr_inc];
            end else if (wr_accept) begin
                tdata_reg <= record;
            end
        end else if (level_reg == '0 && wr_accept) begin
            tdata_reg <= record;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (wr_accept) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (rd_fire) begin
                rd_ptr_reg <= rd_ptr_inc;
            end
            level_reg <= level_reg + LVL_W'(wr_accept) - LVL_W'(rd_fire);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seq_reg         <= '0;
            gap_pending_reg <= 1'b0;
        end else begin
            if (ts_valid) begin
                seq_reg <= seq_reg + 8'd1;
            end
            if (drop) begin
                gap_pending_reg <= 1'b1;
            end else if (wr_accept) begin
                gap_pending_reg <= 1'b0;
            end
        end
    end

    // A drop in the same cycle as a clear wins and restarts the count at one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_reg   <= 1'b0;
            drop_count_reg <= '0;
        end else if (clear_overflow) begin
            overflow_reg   <= drop;
            drop_count_reg <= DROP_COUNT_WIDTH'(drop);
        end else if (drop) begin
            overflow_reg <= 1'b1;
            if (!(&drop_count_reg)) begin
                drop_count_reg <= drop_count_reg + 1'b1;
            end
        end
    end

    assign m_tdata    = tdata_reg;
    assign m_tvalid   = (level_reg != '0);
    assign fifo_level = level_reg;
    assign overflow   = overflow_reg;
    assign drop_count = drop_count_reg;

endmodule
